// File: rtl/xif_offload_master.sv
// XIF offload master: turns a local command into an X-interface issue/commit/result
// transaction with a single outstanding instruction, reporting completion status.
`default_nettype none

package xif_offload_pkg;
  localparam int unsigned X_ID_WIDTH_MAX = 8;

  typedef struct packed {
    logic [31:0]               instr;
    logic [1:0][31:0]          rs;
    logic [X_ID_WIDTH_MAX-1:0] id;
  } x_issue_req_t;

  typedef struct packed {
    logic accept;
    logic writeback;
    logic loadstore;
  } x_issue_resp_t;

  typedef struct packed {
    logic [X_ID_WIDTH_MAX-1:0] id;
    logic                      commit_kill;
  } x_commit_t;

  typedef struct packed {
    logic [X_ID_WIDTH_MAX-1:0] id;
    logic [4:0]                rd;
    logic                      we;
    logic [31:0]               data;
  } x_result_t;
endpackage

module xif_offload_master
  import xif_offload_pkg::*;
#(
  parameter int unsigned X_ID_WIDTH     = 4,    // must not exceed X_ID_WIDTH_MAX
  parameter int unsigned TIMEOUT_CYCLES = 1024  // minimum 2
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          cmd_valid_i,
  output logic          cmd_ready_o,
  input  logic [31:0]   cmd_instr_i,
  input  logic [31:0]   cmd_rs1_i,
  input  logic [31:0]   cmd_rs2_i,
  output logic          xif_issue_valid_o,
  input  logic          xif_issue_ready_i,
  output x_issue_req_t  xif_issue_req_o,
  input  x_issue_resp_t xif_issue_resp_i,
  output logic          xif_commit_valid_o,
  output x_commit_t     xif_commit_o,
  input  logic          xif_result_valid_i,
  output logic          xif_result_ready_o,
  input  x_result_t     xif_result_i,
  output logic          rsp_valid_o,
  output logic [1:0]    rsp_status_o,
  output logic [4:0]    rsp_rd_o,
  output logic          rsp_we_o,
  output logic [31:0]   rsp_data_o,
  output logic          busy_o
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ISSUE   = 3'd1;
  localparam logic [2:0] S_COMMIT  = 3'd2;
  localparam logic [2:0] S_WAIT    = 3'd3;
  localparam logic [2:0] S_RESPOND = 3'd4;

  localparam logic [1:0] ST_OK       = 2'd0;
  localparam logic [1:0] ST_REJECTED = 2'd1;
  localparam logic [1:0] ST_TIMEOUT  = 2'd2;
  localparam logic [1:0] ST_ID_MISM  = 2'd3;

  logic [2:0]            state_q, state_d;
  logic [31:0]           instr_q, instr_d;
  logic [31:0]           rs1_q, rs1_d;
  logic [31:0]           rs2_q, rs2_d;
  logic [X_ID_WIDTH-1:0] id_q, id_d;
  logic [X_ID_WIDTH-1:0] issued_id_q, issued_id_d;
  logic [TW-1:0]         tmo_q, tmo_d;
  logic [1:0]            status_q, status_d;
  logic [4:0]            rd_q, rd_d;
  logic                  we_q, we_d;
  logic [31:0]           data_q, data_d;

  logic id_match;
  logic unused_resp;

  assign id_match    = (xif_result_i.id == X_ID_WIDTH_MAX'(issued_id_q));
  assign unused_resp = xif_issue_resp_i.writeback ^ xif_issue_resp_i.loadstore;

  always_comb begin
    state_d     = state_q;
    instr_d     = instr_q;
    rs1_d       = rs1_q;
    rs2_d       = rs2_q;
    id_d        = id_q;
    issued_id_d = issued_id_q;
    tmo_d       = tmo_q;
    status_d    = status_q;
    rd_d        = rd_q;
    we_d        = we_q;
    data_d      = data_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid_i) begin
          instr_d = cmd_instr_i;
          rs1_d   = cmd_rs1_i;
          rs2_d   = cmd_rs2_i;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (xif_issue_ready_i) begin
          if (xif_issue_resp_i.accept) begin
            issued_id_d = id_q;
            id_d        = id_q + X_ID_WIDTH'(1);
            state_d     = S_COMMIT;
          end else begin
            // A rejected instruction never received an ID, so the counter stays put.
            status_d = ST_REJECTED;
            rd_d     = '0;
            we_d     = 1'b0;
            data_d   = '0;
            state_d  = S_RESPOND;
          end
        end
      end
      S_COMMIT: begin
        tmo_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // A result on the final timeout cycle still wins over the timeout.
        if (xif_result_valid_i) begin
          status_d = id_match ? ST_OK : ST_ID_MISM;
          rd_d     = id_match ? xif_result_i.rd : 5'd0;
          we_d     = id_match ? xif_result_i.we : 1'b0;
          data_d   = id_match ? xif_result_i.data : 32'd0;
          state_d  = S_RESPOND;
        end else if (tmo_q == TMO_LAST) begin
          status_d = ST_TIMEOUT;
          rd_d     = '0;
          we_d     = 1'b0;
          data_d   = '0;
          state_d  = S_RESPOND;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      S_RESPOND: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      instr_q     <= '0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      id_q        <= '0;
      issued_id_q <= '0;
      tmo_q       <= '0;
      status_q    <= ST_OK;
      rd_q        <= '0;
      we_q        <= 1'b0;
      data_q      <= '0;
    end else begin
      state_q     <= state_d;
      instr_q     <= instr_d;
      rs1_q       <= rs1_d;
      rs2_q       <= rs2_d;
      id_q        <= id_d;
      issued_id_q <= issued_id_d;
      tmo_q       <= tmo_d;
      status_q    <= status_d;
      rd_q        <= rd_d;
      we_q        <= we_d;
      data_q      <= data_d;
    end
  end

  assign cmd_ready_o        = (state_q == S_IDLE);
  assign busy_o             = (state_q != S_IDLE);
  assign xif_issue_valid_o  = (state_q == S_ISSUE);
  assign xif_commit_valid_o = (state_q == S_COMMIT);
  // Results are also sunk in IDLE so stale or late responses cannot stall the coprocessor.
  assign xif_result_ready_o = (state_q == S_IDLE) || (state_q == S_WAIT);
  assign rsp_valid_o        = (state_q == S_RESPOND);

  assign xif_issue_req_o = '{instr: instr_q, rs: {rs2_q, rs1_q}, id: X_ID_WIDTH_MAX'(id_q)};
  assign xif_commit_o    = '{id: X_ID_WIDTH_MAX'(issued_id_q), commit_kill: 1'b0};

  assign rsp_status_o = status_q;
  assign rsp_rd_o     = rd_q;
  assign rsp_we_o     = we_q;
  assign rsp_data_o   = data_q;

endmodule

`default_nettype wire

// File: tb/tb_xif_offload_master.sv
// Randomized self-checking bench for xif_offload_master against a transaction-level model.
`default_nettype none

module tb_xif_offload_master;
  import xif_offload_pkg::*;

  localparam int unsigned IDW = 4;
  localparam int unsigned TMO = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [31:0]   cmd_instr, cmd_rs1, cmd_rs2;
  logic          issue_valid, issue_ready;
  x_issue_req_t  issue_req;
  x_issue_resp_t issue_resp;
  logic          commit_valid;
  x_commit_t     commit;
  logic          result_valid, result_ready;
  x_result_t     result;
  logic          rsp_valid;
  logic [1:0]    rsp_status;
  logic [4:0]    rsp_rd;
  logic          rsp_we;
  logic [31:0]   rsp_data;
  logic          busy;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;
  int unsigned model_next_id = 0;

  // Observed transaction
  logic [7:0]  o_id, o_cid;
  logic [31:0] o_instr, o_rs1, o_rs2, o_data;
  int          o_unst, o_cmts, o_lat, o_wait, o_pulse;
  logic [1:0]  o_st;
  logic [4:0]  o_rd;
  logic        o_we;
  // Expected transaction
  logic [7:0]  e_id;
  logic [1:0]  e_st;
  logic [4:0]  e_rd;
  logic        e_we;
  logic [31:0] e_data;
  int          e_lat, e_cmts;

  xif_offload_master #(.X_ID_WIDTH(IDW), .TIMEOUT_CYCLES(TMO)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
    .cmd_instr_i(cmd_instr), .cmd_rs1_i(cmd_rs1), .cmd_rs2_i(cmd_rs2),
    .xif_issue_valid_o(issue_valid), .xif_issue_ready_i(issue_ready),
    .xif_issue_req_o(issue_req), .xif_issue_resp_i(issue_resp),
    .xif_commit_valid_o(commit_valid), .xif_commit_o(commit),
    .xif_result_valid_i(result_valid), .xif_result_ready_o(result_ready),
    .xif_result_i(result),
    .rsp_valid_o(rsp_valid), .rsp_status_o(rsp_status), .rsp_rd_o(rsp_rd),
    .rsp_we_o(rsp_we), .rsp_data_o(rsp_data), .busy_o(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic apply_reset();
    rst_n = 1'b0;
    cmd_valid = 1'b0; issue_ready = 1'b0; issue_resp = '0;
    result_valid = 1'b0; result = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    model_next_id = 0;
  endtask

  // Runs one command to completion (cycle-bounded) and fills o_* / e_* variables.
  // res_delay: cycles after the commit cycle at which the result is presented (0 = never).
  task automatic txn(input logic [31:0] instr, input logic [31:0] rs1, input logic [31:0] rs2,
                     input int stall, input bit accept, input int res_delay,
                     input logic [7:0] res_id, input logic [4:0] rd, input bit we,
                     input logic [31:0] data);
    int cyc = 0, iss_n = 0, cmt_cyc = -1, wait_cyc = -1;
    bit done = 1'b0;
    x_issue_req_t first = '0;
    o_unst = 0; o_cmts = 0; o_cid = '0; o_lat = -1; o_wait = -1;
    o_st = 2'bxx; o_rd = 'x; o_we = 1'bx; o_data = 'x;
    cmd_valid = 1'b1; cmd_instr = instr; cmd_rs1 = rs1; cmd_rs2 = rs2;
    while (!done && cyc < 100) begin
      @(posedge clk); #1; cyc++;
      cmd_valid = 1'b0; issue_ready = 1'b0; result_valid = 1'b0;
      if (issue_valid) begin
        iss_n++;
        if (iss_n == 1) first = issue_req;
        else if (issue_req !== first) o_unst++;
        issue_ready = (iss_n > stall);
        issue_resp  = '{accept: accept, writeback: 1'($urandom_range(0, 1)),
                        loadstore: 1'($urandom_range(0, 1))};
      end
      if (commit_valid) begin o_cmts++; o_cid = commit.id; cmt_cyc = cyc; end
      if (result_ready && busy && wait_cyc < 0) wait_cyc = cyc;
      if (rsp_valid) begin
        done = 1'b1; o_lat = cyc + 1;
        o_st = rsp_status; o_rd = rsp_rd; o_we = rsp_we; o_data = rsp_data;
        o_wait = (wait_cyc < 0) ? -1 : cyc - wait_cyc;
      end else if (res_delay > 0 && cmt_cyc >= 0 && cyc == cmt_cyc + res_delay) begin
        result_valid = 1'b1;
        result = '{id: res_id, rd: rd, we: we, data: data};
      end
    end
    o_id = first.id; o_instr = first.instr; o_rs1 = first.rs[0]; o_rs2 = first.rs[1];
    @(posedge clk); #1;
    o_pulse = done ? (rsp_valid ? 2 : 1) : 0;

    // Reference model: cycles = cmd handshake + ISSUE(stall+1) + COMMIT + WAIT + RESPOND
    e_id = 8'(model_next_id);
    if (!accept) begin
      e_cmts = 0; e_st = 2'd1; e_lat = 1 + (stall + 1) + 1;
    end else begin
      e_cmts = 1;
      model_next_id = (model_next_id + 1) % (1 << IDW);
      if (res_delay >= 1 && res_delay <= int'(TMO)) begin
        e_lat = 1 + (stall + 1) + 1 + res_delay + 1;
        e_st  = (res_id == e_id) ? 2'd0 : 2'd3;
      end else begin
        e_lat = 1 + (stall + 1) + 1 + int'(TMO) + 1;
        e_st  = 2'd2;
      end
    end
    if (e_st == 2'd0) begin e_rd = rd; e_we = we; e_data = data; end
    else begin e_rd = '0; e_we = 1'b0; e_data = '0; end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cmd_valid = 1'b0; cmd_instr = '0; cmd_rs1 = '0; cmd_rs2 = '0;
    issue_ready = 1'b0; issue_resp = '0; result_valid = 1'b0; result = '0;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if ({issue_valid, commit_valid, rsp_valid, busy, rsp_status, rsp_rd, rsp_we, rsp_data} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got v%b c%b r%b b%b st%0d rd%0d we%b d%h, expected all 0",
               issue_valid, commit_valid, rsp_valid, busy, rsp_status, rsp_rd, rsp_we, rsp_data);
    end
    vectors++;
    if ({cmd_ready, result_ready} !== 2'b11) begin
      miscompares++;
      $display("FAIL reset_ready: got cmd_ready=%b result_ready=%b, expected 1 1", cmd_ready, result_ready);
    end
    vectors++;
    if ({issue_req, commit} !== '0) begin
      miscompares++;
      $display("FAIL reset_req: got issue_req=%h commit=%h, expected 0", issue_req, commit);
    end
    #1 rst_n = 1'b1;
    model_next_id = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic_add();
    logic [31:0] a = $urandom, b = $urandom;
    txn(32'h0020_818B, a, b, 0, 1'b1, 2, 8'd0, 5'd3, 1'b1, 32'd0);
    vectors++;
    if ({o_id, o_instr, o_rs1, o_rs2} !== {8'd0, 32'h0020_818B, a, b}) begin
      miscompares++;
      $display("FAIL basic_req: got id%0d %h %h %h, expected id0 0020818b %h %h", o_id, o_instr, o_rs1, o_rs2, a, b);
    end
    vectors++;
    if (o_cmts !== 1 || o_cid !== 8'd0) begin
      miscompares++;
      $display("FAIL basic_commit: got %0d commits id %0d, expected 1 commit id 0", o_cmts, o_cid);
    end
    vectors++;
    if ({o_st, o_rd, o_we, o_data} !== {2'd0, 5'd3, 1'b1, 32'd0} || o_pulse !== 1) begin
      miscompares++;
      $display("FAIL basic_rsp: got st%0d rd%0d we%b d%h pulse%0d, expected st0 rd3 we1 d0 pulse1",
               o_st, o_rd, o_we, o_data, o_pulse);
    end
    vectors++;
    if (o_lat !== e_lat) begin
      miscompares++;
      $display("FAIL basic_latency: got %0d, expected %0d", o_lat, e_lat);
    end
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if ({rsp_status, rsp_rd, rsp_we} !== {2'd0, 5'd3, 1'b1} || rsp_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_hold: got st%0d rd%0d we%b valid%b, expected st0 rd3 we1 valid0",
               rsp_status, rsp_rd, rsp_we, rsp_valid);
    end
    txn($urandom, $urandom, $urandom, 0, 1'b1, 1, 8'd1, 5'd7, 1'b0, $urandom);
    vectors++;
    if (o_id !== 8'd1 || o_lat !== 5) begin
      miscompares++;
      $display("FAIL basic_next: got id %0d latency %0d, expected id 1 latency 5", o_id, o_lat);
    end
  endtask

  task automatic test_reject();
    int st = $urandom_range(0, 2);
    apply_reset();
    txn($urandom, $urandom, $urandom, st, 1'b0, 2, 8'd0, 5'd1, 1'b1, $urandom);
    vectors++;
    if (o_cmts !== 0 || o_st !== 2'd1 || o_lat !== e_lat || {o_rd, o_we, o_data} !== '0) begin
      miscompares++;
      $display("FAIL reject: got commits%0d st%0d lat%0d data%h, expected commits0 st1 lat%0d data0",
               o_cmts, o_st, o_lat, o_data, e_lat);
    end
    txn($urandom, $urandom, $urandom, 0, 1'b1, 1, 8'd0, 5'd2, 1'b1, 32'h1234_5678);
    vectors++;
    if (o_id !== 8'd0 || o_cid !== 8'd0 || o_st !== 2'd0) begin
      miscompares++;
      $display("FAIL reject_next_id: got issue %0d commit %0d st %0d, expected 0 0 0", o_id, o_cid, o_st);
    end
  endtask

  task automatic test_backpressure_wrap();
    apply_reset();
    for (int i = 0; i < 17; i++) begin
      txn($urandom, $urandom, $urandom, (i == 0) ? 7 : 0, 1'b1, 1, 8'(i % 16), 5'(i), 1'b1, $urandom);
      vectors++;
      if (o_id !== 8'(i % 16) || o_cid !== 8'(i % 16) || o_st !== 2'd0) begin
        miscompares++;
        $display("FAIL wrap[%0d]: got issue %0d commit %0d st %0d, expected %0d %0d 0",
                 i, o_id, o_cid, o_st, i % 16, i % 16);
      end
      if (i == 0) begin
        vectors++;
        if (o_unst !== 0 || o_lat !== e_lat) begin
          miscompares++;
          $display("FAIL backpressure: got %0d unstable cycles latency %0d, expected 0 and %0d",
                   o_unst, o_lat, e_lat);
        end
      end
    end
  endtask

  task automatic test_timeout();
    int pulses = 0;
    bit ok = 1'b1;
    apply_reset();
    txn($urandom, $urandom, $urandom, 0, 1'b1, 0, 8'd0, 5'd0, 1'b0, 32'd0);
    vectors++;
    if (o_st !== 2'd2 || o_wait !== int'(TMO) || o_lat !== e_lat) begin
      miscompares++;
      $display("FAIL timeout: got st%0d wait%0d lat%0d, expected st2 wait%0d lat%0d", o_st, o_wait, o_lat, TMO, e_lat);
    end
    result_valid = 1'b1;
    result = '{id: 8'd0, rd: 5'd9, we: 1'b1, data: $urandom};
    vectors++;
    if (result_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL late_ready: got result_ready=%b, expected 1", result_ready);
    end
    @(posedge clk); #1;
    result_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (rsp_valid) pulses++;
      if (busy || rsp_status !== 2'd2 || rsp_rd !== 5'd0 || rsp_data !== 32'd0) ok = 1'b0;
      @(posedge clk); #1;
    end
    vectors++;
    if (pulses !== 0 || !ok) begin
      miscompares++;
      $display("FAIL late_discard: got %0d pulses, outputs kept=%b, expected 0 pulses and kept", pulses, ok);
    end
    txn($urandom, $urandom, $urandom, 0, 1'b1, TMO, 8'd1, 5'd4, 1'b1, 32'hCAFE_0001);
    vectors++;
    if ({o_st, o_rd, o_data} !== {2'd0, 5'd4, 32'hCAFE_0001} || o_lat !== e_lat) begin
      miscompares++;
      $display("FAIL timeout_edge_result: got st%0d rd%0d d%h lat%0d, expected st0 rd4 cafe0001 lat%0d",
               o_st, o_rd, o_data, o_lat, e_lat);
    end
    txn($urandom, $urandom, $urandom, 0, 1'b1, TMO + 1, 8'd2, 5'd4, 1'b1, 32'hCAFE_0002);
    vectors++;
    if (o_st !== 2'd2 || o_lat !== e_lat) begin
      miscompares++;
      $display("FAIL timeout_edge_late: got st%0d lat%0d, expected st2 lat%0d", o_st, o_lat, e_lat);
    end
  endtask

  task automatic test_id_mismatch();
    apply_reset();
    for (int i = 0; i < 2; i++)
      txn($urandom, $urandom, $urandom, 0, 1'b1, 1, 8'(i), 5'd1, 1'b1, $urandom);
    txn($urandom, $urandom, $urandom, 0, 1'b1, 1, 8'd5, 5'd6, 1'b1, 32'hDEAD_BEEF);
    vectors++;
    if (o_id !== 8'd2 || o_st !== 2'd3 || {o_rd, o_we, o_data} !== '0) begin
      miscompares++;
      $display("FAIL id_mismatch: got id%0d st%0d rd%0d we%b d%h, expected id2 st3 rd0 we0 d0",
               o_id, o_st, o_rd, o_we, o_data);
    end
  endtask

  task automatic test_reset_in_wait();
    bit reached = 1'b0;
    int pulses = 0;
    apply_reset();
    txn($urandom, $urandom, $urandom, 0, 1'b1, 1, 8'd0, 5'd1, 1'b1, $urandom);
    cmd_valid = 1'b1; cmd_instr = $urandom; issue_ready = 1'b1;
    issue_resp = '{accept: 1'b1, writeback: 1'b0, loadstore: 1'b0};
    for (int i = 0; i < 10 && !reached; i++) begin
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      if (busy && result_ready) reached = 1'b1;
    end
    issue_ready = 1'b0;
    vectors++;
    if (!reached) begin
      miscompares++;
      $display("FAIL rst_wait_reach: got no WAIT_RESULT within 10 cycles, expected it within 3");
    end
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if ({busy, cmd_ready, rsp_valid, commit_valid, issue_valid} !== 5'b01000) begin
      miscompares++;
      $display("FAIL rst_wait_async: got busy%b cmd_ready%b rsp%b, expected busy0 cmd_ready1 rsp0",
               busy, cmd_ready, rsp_valid);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    model_next_id = 0;
    for (int i = 0; i < 4; i++) begin
      if (rsp_valid) pulses++;
      @(posedge clk); #1;
    end
    vectors++;
    if (pulses !== 0) begin
      miscompares++;
      $display("FAIL rst_wait_pulse: got %0d rsp pulses, expected 0", pulses);
    end
    txn($urandom, $urandom, $urandom, 0, 1'b1, 1, 8'd0, 5'd2, 1'b1, $urandom);
    vectors++;
    if (o_id !== 8'd0 || o_st !== 2'd0) begin
      miscompares++;
      $display("FAIL rst_wait_next_id: got id %0d st %0d, expected id 0 st 0", o_id, o_st);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      bit          acc = ($urandom_range(0, 3) != 0);
      int          stall = $urandom_range(0, 3);
      int          d = $urandom_range(0, TMO + 2);
      logic [7:0]  rid = 8'(model_next_id);
      if ($urandom_range(0, 4) == 0) rid = rid ^ 8'($urandom_range(1, 255));
      txn($urandom, $urandom, $urandom, stall, acc, d, rid, 5'($urandom), 1'($urandom), $urandom);
      vectors++;
      if (o_id !== e_id || o_cmts !== e_cmts) begin
        miscompares++;
        $display("FAIL rand_issue[%0d]: got id%0d commits%0d, expected id%0d commits%0d", i, o_id, o_cmts, e_id, e_cmts);
      end
      vectors++;
      if ({o_st, o_rd, o_we, o_data} !== {e_st, e_rd, e_we, e_data}) begin
        miscompares++;
        $display("FAIL rand_rsp[%0d]: got st%0d rd%0d we%b d%h, expected st%0d rd%0d we%b d%h",
                 i, o_st, o_rd, o_we, o_data, e_st, e_rd, e_we, e_data);
      end
      vectors++;
      if (o_lat !== e_lat || o_pulse !== 1) begin
        miscompares++;
        $display("FAIL rand_timing[%0d]: got latency%0d pulse%0d, expected latency%0d pulse1", i, o_lat, o_pulse, e_lat);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_add();
    test_reject();
    test_backpressure_wrap();
    test_timeout();
    test_id_mismatch();
    test_reset_in_wait();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/xif_offload_master.md
XIF_OFFLOAD_MASTER -- requirements
Module: xif_offload_master

Interface
REQ-001 Parameter X_ID_WIDTH, default 4, width of the XIF instruction ID.
REQ-002 Parameter TIMEOUT_CYCLES, default 1024, maximum cycles spent waiting for a result (minimum 2).
REQ-003 clk_i  input  1  the single clock; all state updates on its rising edge.
REQ-004 rst_ni  input  1  reset: asynchronous assert, active-low.
REQ-005 cmd_valid_i  input  1  local request to offload one instruction.
REQ-006 cmd_ready_o  output  1  request accepted; high only in IDLE.
REQ-007 cmd_instr_i  input  32  instruction word to offload.
REQ-008 cmd_rs1_i / cmd_rs2_i  input  32 each  scalar operands forwarded as rs[0] / rs[1].
REQ-009 xif_issue_valid_o  output  1  issue request valid.
REQ-010 xif_issue_ready_i  input  1  coprocessor ready for issue.
REQ-011 xif_issue_req_o  output  x_issue_req_t  instr, rs[0], rs[1], id.
REQ-012 xif_issue_resp_i  input  x_issue_resp_t  accept, writeback, loadstore.
REQ-013 xif_commit_valid_o  output  1  commit strobe.
REQ-014 xif_commit_o  output  x_commit_t  id; commit_kill always 0.
REQ-015 xif_result_valid_i  input  1  result valid from coprocessor.
REQ-016 xif_result_ready_o  output  1  result sink ready.
REQ-017 xif_result_i  input  x_result_t  id, rd, we, data.
REQ-018 rsp_valid_o  output  1  one-cycle completion pulse.
REQ-019 rsp_status_o  output  2  0=OK, 1=REJECTED, 2=TIMEOUT, 3=ID_MISMATCH.
REQ-020 rsp_rd_o / rsp_we_o / rsp_data_o  output  5 / 1 / 32  captured result fields (0 unless status OK).
REQ-021 busy_o  output  1  high in every state except IDLE.

Function
REQ-022 States: IDLE, ISSUE, COMMIT, WAIT_RESULT, RESPOND; exactly one transaction is outstanding at a time.
REQ-023 IDLE: cmd_ready_o=1; cmd_valid_i=1 latches instr/rs1/rs2 and moves to ISSUE, so xif_issue_valid_o rises the next cycle.
REQ-024 ISSUE: xif_issue_valid_o=1 with req fields stable until xif_issue_ready_i=1; on that handshake cycle, accept is sampled.
REQ-025 Handshake with accept=1 -> COMMIT; with accept=0 -> RESPOND with status REJECTED; the ID is not consumed on reject.
REQ-026 COMMIT: xif_commit_valid_o=1 for exactly one cycle with commit.id equal to the issued id, then WAIT_RESULT.
REQ-027 WAIT_RESULT: xif_result_ready_o=1; on valid&&ready, if result.id equals the issued id, capture rd/we/data[31:0] with status OK, otherwise set status ID_MISMATCH; either way -> RESPOND.
REQ-028 WAIT_RESULT: a timeout counter cleared on entry increments each cycle; reaching TIMEOUT_CYCLES-1 without a result -> RESPOND with status TIMEOUT.
REQ-029 A result arriving in the same cycle the timeout expires is treated as a result, not a timeout.
REQ-030 RESPOND: rsp_valid_o=1 for one cycle, then IDLE; the status and data outputs hold until the next RESPOND.
REQ-031 ID counter increments (mod 2^X_ID_WIDTH, wrapping from max to 0) on every accepted issue handshake.
REQ-032 In IDLE, xif_result_ready_o=1, and any result received there (late or stale) is discarded without affecting outputs.
REQ-033 xif_result_ready_o=0 in ISSUE, COMMIT and RESPOND.
REQ-034 Minimum accepted-transaction latency from cmd handshake to rsp_valid_o is 5 cycles, assuming issue_ready=1 and the result comes in the first WAIT_RESULT cycle.

Reset
REQ-035 Reset asserted in any state returns to IDLE within the same cycle (asynchronous).
REQ-036 On reset, all outputs are 0 except cmd_ready_o=1 and xif_result_ready_o=1; the ID counter, timeout counter and captured fields are all 0.
REQ-037 A transaction in flight when reset asserts is abandoned, with no rsp_valid_o pulse.

Verification
REQ-038 Basic add: cmd instr=custom0 VADD, issue_ready=1, accept=1, result id=0, rd=3, we=1, data=0 returned 2 cycles after commit -> one commit with id=0, rsp_valid pulse, status=0, rsp_rd=3, next id=1.
REQ-039 Reject: accept=0 on handshake -> no commit, status=1, the following transaction still uses id=0.
REQ-040 Backpressure plus wrap: issue_ready low for 7 cycles, with issue_req held stable across them; run 17 accepted transactions -> ids 0..15, then 0.
REQ-041 Timeout: TIMEOUT_CYCLES=8 and no result -> status=2 exactly 8 cycles after WAIT_RESULT entry; a late result then sent in IDLE is consumed, with no rsp_valid pulse.
REQ-042 ID mismatch: result.id=5 while issued id=2 -> status=3 and rsp_data=0.
REQ-043 Reset in WAIT_RESULT: rst_ni low for 1 cycle -> busy_o=0 immediately, no rsp_valid pulse, and the next issue uses id=0.
